// File: rtl/add_pkg.sv
// add_pkg: shared types and constants for the adder result buffer.
//   ADD_WIDTH      - adder data width
//   FLAG_*         - bit positions inside add_result_t.flags
//   add_result_t   - FIFO entry {sum, flags[3:0]}
//   add_flags()    - status flag derivation from a raw adder result
package add_pkg;

  localparam int ADD_WIDTH  = 32;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic [3:0]           flags;
  } add_result_t;

  // Signed overflow: both operands share a sign and the sum's sign differs from it.
  function automatic logic [3:0] add_flags(input logic [ADD_WIDTH-1:0] sum,
                                           input logic c_out,
                                           input logic a_msb,
                                           input logic b_msb);
    logic [3:0] f;
    f             = 4'b0000;
    f[FLAG_CARRY] = c_out;
    f[FLAG_ZERO]  = (sum == {ADD_WIDTH{1'b0}});
    f[FLAG_NEG]   = sum[ADD_WIDTH-1];
    f[FLAG_OVF]   = (a_msb == b_msb) && (sum[ADD_WIDTH-1] != a_msb);
    return f;
  endfunction

endpackage

// File: rtl/add_result_buffer_if.sv
// add_result_buffer_if: handshake bundle between the adder, the result
// buffer and the consuming stage.
//   in_valid/in_ready, sum_in, c_out_in, a_msb, b_msb   - upstream side
//   out_valid/out_ready, out_sum, out_carry, out_zero,
//   out_neg, out_ovf                                     - downstream side
// Modports: master = environment (adder + consumer), slave = the buffer.
interface add_result_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic             c_out_in;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport master (
    output in_valid, sum_in, c_out_in, a_msb, b_msb, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_zero, out_neg, out_ovf
  );

  modport slave (
    input  in_valid, sum_in, c_out_in, a_msb, b_msb, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/add_result_fifo.sv
// add_result_fifo: DEPTH-entry synchronous FIFO of add_result_t.
//   clk, rst      - clock, async active-high reset
//   push_i/data_i - write side (ignored when full)
//   pop_i         - read side (ignored when empty)
//   data_o        - head entry (storage read, no bypass)
//   level_o       - occupancy, one bit wider than the pointers
module add_result_fifo
  import add_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  add_result_t            data_i,
  input  logic                   pop_i,
  output add_result_t            data_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  add_result_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          push_s;
  logic          pop_s;

  // Guard against overrun/underrun even if the caller misbehaves.
  assign push_s = push_i && (level_q != LW'(DEPTH));
  assign pop_s  = pop_i && (level_q != {LW{1'b0}});

  // Occupancy next state.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
endmodule

// File: rtl/add_result_buffer.sv
// add_result_buffer: captures adder results with derived status flags into a
// small FIFO and keeps a saturating carry-event counter.
//   clk, rst    - clock, async active-high reset
//   bus         - add_result_buffer_if.slave (in/out handshakes and data)
//   clr_cnt     - synchronous clear of carry_cnt (wins over increment)
//   carry_cnt   - saturating count of pushes with carry-out
//   level       - FIFO occupancy
// Optional (macro ADD_RESULT_STICKY_EN): clr_sticky input, sticky_ovf output,
// a sticky record of any pushed signed overflow (set wins over clear).
module add_result_buffer
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  add_result_buffer_if.slave     bus,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       carry_cnt,
`ifdef ADD_RESULT_STICKY_EN
  input  logic                   clr_sticky,
  output logic                   sticky_ovf,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;

  add_result_t   entry_s;
  add_result_t   head_s;
  logic [LW-1:0] level_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_s;
  logic [CNT_W-1:0] carry_cnt_q;

  // in_ready comes from registered occupancy only, never from out_ready.
  assign bus.in_ready = (level_s != LW'(DEPTH));
  assign valid_s      = (level_s != {LW{1'b0}});
  assign push_s       = bus.in_valid && bus.in_ready;
  assign pop_s        = valid_s && bus.out_ready;

  assign entry_s.sum   = bus.sum_in;
  assign entry_s.flags = add_flags(bus.sum_in, bus.c_out_in, bus.a_msb, bus.b_msb);

  add_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (entry_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .level_o (level_s)
  );

  // Head presentation; data is zeroed while the FIFO is empty.
  always_comb begin
    bus.out_valid = valid_s;
    if (valid_s) begin
      bus.out_sum   = WIDTH'(head_s.sum);
      bus.out_carry = head_s.flags[FLAG_CARRY];
      bus.out_zero  = head_s.flags[FLAG_ZERO];
      bus.out_neg   = head_s.flags[FLAG_NEG];
      bus.out_ovf   = head_s.flags[FLAG_OVF];
    end else begin
      bus.out_sum   = {WIDTH{1'b0}};
      bus.out_carry = 1'b0;
      bus.out_zero  = 1'b0;
      bus.out_neg   = 1'b0;
      bus.out_ovf   = 1'b0;
    end
  end

  // Saturating carry-event counter; clear beats a concurrent increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt_q <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      carry_cnt_q <= {CNT_W{1'b0}};
    end else if (push_s && bus.c_out_in && (carry_cnt_q != {CNT_W{1'b1}})) begin
      carry_cnt_q <= carry_cnt_q + CNT_W'(1);
    end else begin
      carry_cnt_q <= carry_cnt_q;
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign level     = level_s;

`ifdef ADD_RESULT_STICKY_EN
  logic sticky_ovf_q;

  // Sticky overflow record; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
    end else if (push_s && entry_s.flags[FLAG_OVF]) begin
      sticky_ovf_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_q;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`endif
endmodule

// File: tb/tb_add_result_buffer.sv
module tb_add_result_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             clr_cnt;
  logic [CNT_W-1:0] carry_cnt;
  logic [2:0]       level;
`ifdef ADD_RESULT_STICKY_EN
  logic             clr_sticky;
  logic             sticky_ovf;
`endif

  add_result_buffer_if #(.WIDTH(32)) bus ();

  add_result_buffer #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_cnt    (clr_cnt),
    .carry_cnt  (carry_cnt),
`ifdef ADD_RESULT_STICKY_EN
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
`endif
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of results plus a counter and a sticky bit.
  typedef struct {
    logic [31:0] sum;
    bit          c, z, n, o;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cnt;
  bit          m_sticky;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] s, input bit c, input bit am, input bit bm);
    ent_t e;
    bit   sm;
    sm  = s[31];
    e.sum = s;
    e.c = c;
    e.z = (s == 32'd0);
    e.n = sm;
    e.o = (am == bm) && (sm != am);
    return e;
  endfunction

  task automatic compare_all();
    ent_t h;
    bit   v;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    else   h = '{sum: 32'd0, c: 1'b0, z: 1'b0, n: 1'b0, o: 1'b0};
    chk("out_valid", 64'(bus.out_valid), 64'(v));
    chk("out_sum",   64'(bus.out_sum),   64'(h.sum));
    chk("out_carry", 64'(bus.out_carry), 64'(h.c));
    chk("out_zero",  64'(bus.out_zero),  64'(h.z));
    chk("out_neg",   64'(bus.out_neg),   64'(h.n));
    chk("out_ovf",   64'(bus.out_ovf),   64'(h.o));
    chk("level",     64'(level),         64'(mq.size()));
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() != DEPTH));
    chk("carry_cnt", 64'(carry_cnt),     64'(m_cnt));
`ifdef ADD_RESULT_STICKY_EN
    chk("sticky_ovf", 64'(sticky_ovf),   64'(m_sticky));
`endif
  endtask

  // One clock: model decisions use pre-edge inputs, then compare after the edge.
  task automatic step();
    bit   push, pop, clr, clrs;
    ent_t e;
    push = bus.in_valid && (mq.size() < DEPTH);
    pop  = bus.out_ready && (mq.size() > 0);
    clr  = clr_cnt;
    clrs = 1'b0;
`ifdef ADD_RESULT_STICKY_EN
    clrs = clr_sticky;
`endif
    e = mk(bus.sum_in, bus.c_out_in, bus.a_msb, bus.b_msb);
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (clr) m_cnt = 0;
    else if (push && e.c) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (push && e.o) m_sticky = 1'b1;
    else if (clrs)   m_sticky = 1'b0;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] s, input bit c, input bit am,
                       input bit bm, input bit rdy);
    bus.in_valid  = v;
    bus.sum_in    = s;
    bus.c_out_in  = c;
    bus.a_msb     = am;
    bus.b_msb     = bm;
    bus.out_ready = rdy;
  endtask

  typedef struct {
    logic [31:0] sum;
    bit c, am, bm;
    bit ez, en, eo, ec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks = 0; errors = 0; m_cnt = 0; m_sticky = 1'b0;
    rst = 1'b1; clr_cnt = 1'b0;
`ifdef ADD_RESULT_STICKY_EN
    clr_sticky = 1'b0;
`endif
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state while reset is held.
    #12;
    compare_all();
    #5 rst = 1'b0;

    // Table: push one vector, check flags at N+1, then pop it.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].sum, vecs[i].c, vecs[i].am, vecs[i].bm, 1'b0);
      step();
      chk("tbl_valid", 64'(bus.out_valid), 64'd1);
      chk("tbl_sum",   64'(bus.out_sum),   64'(vecs[i].sum));
      chk("tbl_zero",  64'(bus.out_zero),  64'(vecs[i].ez));
      chk("tbl_neg",   64'(bus.out_neg),   64'(vecs[i].en));
      chk("tbl_ovf",   64'(bus.out_ovf),   64'(vecs[i].eo));
      chk("tbl_carry", 64'(bus.out_carry), 64'(vecs[i].ec));
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("tbl_empty", 64'(bus.out_valid), 64'd0);
    end

    // Fill to DEPTH with out_ready low; a fifth result is dropped.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4);
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drop_level", 64'(level), 64'd4);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_sum", 64'(bus.out_sum), 64'(i));
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_sum0",  64'(bus.out_sum),   64'd0);

    // Continuous stream: level settles at 1, one result per cycle in order.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_sum", 64'(bus.out_sum), 64'(32'h100 + i));
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Counter saturation at 2^CNT_W-1, then clear beats a concurrent carry push.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk("cnt_sat", 64'(carry_cnt), 64'(CMAX));
    clr_cnt = 1'b1;
    step();
    chk("cnt_clr", 64'(carry_cnt), 64'd0);
    clr_cnt = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

`ifdef ADD_RESULT_STICKY_EN
    // Sticky: set on overflow push, same-cycle set and clear keeps it set.
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    chk("sticky_setwin", 64'(sticky_ovf), 64'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clr_sticky = 1'b0;
    chk("sticky_clr", 64'(sticky_ovf), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      clr_cnt = ($urandom_range(0, 31) == 0);
`ifdef ADD_RESULT_STICKY_EN
      clr_sticky = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    clr_cnt = 1'b0;

    // Async reset with level=3 and no clock edge.
    drive(1'b1, 32'hA, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (mq.size() != 0) step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h50 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("pre_rst_level", 64'(level), 64'd3);
    #1 rst = 1'b1;
    #1;
    mq.delete();
    m_cnt = 0;
    m_sticky = 1'b0;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_sum",   64'(bus.out_sum), 64'd0);
    compare_all();
    #2 rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
